// File: rtl/time_counter_12hr.sv
// Timekeeping core for the seven-segment clock.
// Holds 12-hour BCD hours/minutes with AM/PM and an internal seconds count.
// The seconds count advances on a 1 Hz tick divided down from the system clock.
// Two debounced push-buttons step the hours and the minutes.

// Button conditioner: a 2-FF synchroniser followed by a debouncer.
// set_pulse is high for one cycle when the accepted level rises.
module time_counter_12hr_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset_n,
  input  logic btn_raw,
  output logic set_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          accepted_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments, so every
      // flop samples the values from before the edge and stage order does not matter.
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has persisted for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      accepted_q <= 1'b0;
      cnt_q      <= '0;
      set_pulse  <= 1'b0;
    end else begin
      set_pulse <= 1'b0;
      if (sync_q2 == accepted_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        accepted_q <= sync_q2;
        cnt_q      <= '0;
        // Only a press produces a pulse. A release is accepted silently.
        set_pulse  <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// Top level: prescaler, time registers and the two button conditioners.
module time_counter_12hr #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       btn_hrs,
  input  logic       btn_mins,
  output logic [2:0] hrs_tens,
  output logic [3:0] hrs_ones,
  output logic [2:0] mins_tens,
  output logic [3:0] mins_ones,
  output logic       pm,
  output logic       sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
    logic       pm;
  } hours_t;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } minutes_t;

  localparam hours_t   HOURS_RESET = '{tens: 3'd1, ones: 4'd2, pm: 1'b0};
  localparam minutes_t MINS_RESET  = '{tens: 3'd0, ones: 4'd0};

  logic [PW-1:0] presc_q;
  logic [5:0]    secs_q;
  logic [5:0]    secs_d;
  hours_t        hours_q;
  hours_t        hours_d;
  minutes_t      mins_q;
  minutes_t      mins_d;
  logic          tick;
  logic          hrs_set;
  logic          mins_set;
  logic          mins_wrap;

  // Advance the hours along 12, 01 .. 11, 12. PM flips on the 11 -> 12 step.
  function automatic hours_t next_hours(input hours_t cur);
    hours_t nxt;
    nxt = cur;
    if (cur.tens == 3'd1 && cur.ones == 4'd2) begin
      nxt.tens = 3'd0;
      nxt.ones = 4'd1;
    end else if (cur.tens == 3'd1 && cur.ones == 4'd1) begin
      nxt.ones = 4'd2;
      nxt.pm   = ~cur.pm;
    end else if (cur.ones == 4'd9) begin
      nxt.tens = 3'd1;
      nxt.ones = 4'd0;
    end else begin
      nxt.ones = cur.ones + 4'd1;
    end
    return nxt;
  endfunction

  // Advance the minutes along 00 .. 59, 00. The caller decides on any carry.
  function automatic minutes_t next_minutes(input minutes_t cur);
    minutes_t nxt;
    nxt = cur;
    if (cur.ones == 4'd9) begin
      nxt.ones = 4'd0;
      nxt.tens = (cur.tens == 3'd5) ? 3'd0 : cur.tens + 3'd1;
    end else begin
      nxt.ones = cur.ones + 4'd1;
    end
    return nxt;
  endfunction

  time_counter_12hr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_hrs (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .btn_raw   (btn_hrs),
    .set_pulse (hrs_set)
  );

  time_counter_12hr_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_mins (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .btn_raw   (btn_mins),
    .set_pulse (mins_set)
  );

  assign tick      = (presc_q == PRESC_LAST);
  assign mins_wrap = (mins_q.tens == 3'd5) && (mins_q.ones == 4'd9);

  // Divide the clock to the 1 Hz tick. A minutes set restarts the second.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      if (tick || mins_set) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Next time value. Any set pulse takes priority and drops that tick's update.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    secs_d  = secs_q;
    mins_d  = mins_q;
    hours_d = hours_q;
    if (hrs_set || mins_set) begin
      if (hrs_set) begin
        hours_d = next_hours(hours_q);
      end
      if (mins_set) begin
        mins_d = next_minutes(mins_q);
        secs_d = 6'd0;
      end
    end else if (tick) begin
      if (secs_q == 6'd59) begin
        secs_d = 6'd0;
        mins_d = next_minutes(mins_q);
        if (mins_wrap) begin
          hours_d = next_hours(hours_q);
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
    end
  end

  // Time registers, cleared to 12:00:00 AM.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      secs_q  <= 6'd0;
      mins_q  <= MINS_RESET;
      hours_q <= HOURS_RESET;
    end else begin
      secs_q  <= secs_d;
      mins_q  <= mins_d;
      hours_q <= hours_d;
    end
  end

  assign hrs_tens  = hours_q.tens;
  assign hrs_ones  = hours_q.ones;
  assign pm        = hours_q.pm;
  assign mins_tens = mins_q.tens;
  assign mins_ones = mins_q.ones;

endmodule

// File: tb/tb_time_counter_12hr.sv
// Bench for time_counter_12hr with CLK_HZ=10 and DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected display value for each change it provokes.
// The monitor pops one entry per observed display change and compares it.
module tb_time_counter_12hr;

  logic       clk_100MHz;
  logic       reset_n;
  logic       btn_hrs;
  logic       btn_mins;
  logic [2:0] hrs_tens;
  logic [3:0] hrs_ones;
  logic [2:0] mins_tens;
  logic [3:0] mins_ones;
  logic       pm;
  logic       sec_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_count = 0;
  int last_chg   = 0;
  int prev_chg   = 0;

  logic [14:0] exp_q[$];
  logic [14:0] prev_disp;

  time_counter_12hr #(
    .CLK_HZ         (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .btn_hrs   (btn_hrs),
    .btn_mins  (btn_mins),
    .hrs_tens  (hrs_tens),
    .hrs_ones  (hrs_ones),
    .mins_tens (mins_tens),
    .mins_ones (mins_ones),
    .pm        (pm),
    .sec_tick  (sec_tick)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [14:0] disp();
    return {hrs_tens, hrs_ones, mins_tens, mins_ones, pm};
  endfunction

  // Display value from hand-written decimal hour/minute and am/pm.
  function automatic logic [14:0] mk(input int h, input int m, input bit p);
    return {3'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), p};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic push_exp(input int h, input int m, input bit p);
    exp_q.push_back(mk(h, m, p));
  endtask

  task automatic press(input bit bh, input bit bm, input int hold);
    btn_hrs  = bh;
    btn_mins = bm;
    cyc(hold);
    btn_hrs  = 1'b0;
    btn_mins = 1'b0;
    cyc(8);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_100MHz);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: count ticks and compare every display change against the queue.
  always @(negedge clk_100MHz) begin
    if (!reset_n) begin
      prev_disp = disp();
    end else begin
      if (sec_tick) tick_count++;
      if (disp() != prev_disp) begin
        prev_chg = last_chg;
        last_chg = tick_count;
        if (exp_q.size() == 0) check("unexpected_change", disp(), prev_disp);
        else check("display", disp(), exp_q.pop_front());
        prev_disp = disp();
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks;
    reset_n  = 1'b0;
    btn_hrs  = 1'b0;
    btn_mins = 1'b0;
    cyc(3);
    check("reset_display", disp(), mk(12, 0, 0));
    check("reset_sec_tick", sec_tick, 0);

    // One second after release: exactly one tick, display untouched.
    reset_n = 1'b1;
    ticks = 0;
    repeat (10) begin
      @(negedge clk_100MHz);
      if (sec_tick) ticks++;
    end
    check("ticks_in_10_cycles", ticks, 1);
    check("display_after_1s", disp(), mk(12, 0, 0));

    // Hours 12 -> 01 .. 11 AM, passing 09 -> 10.
    for (int h = 1; h <= 11; h++) begin
      push_exp(h, 0, 0);
      press(1'b1, 1'b0, 8);
      wait_drain("hrs_press_am", 20);
    end
    for (int m = 1; m <= 59; m++) begin
      push_exp(11, m, 0);
      press(1'b0, 1'b1, 8);
      wait_drain("mins_to_1159am", 20);
    end

    // Tick-driven 11:59:59 AM -> 12:00 PM, seconds restarted by the last press.
    push_exp(12, 0, 1);
    wait_drain("tick_to_noon", 700);
    check("noon_after_60_ticks", last_chg - prev_chg, 60);

    for (int m = 1; m <= 59; m++) begin
      push_exp(12, m, 1);
      press(1'b0, 1'b1, 8);
      wait_drain("mins_to_1259pm", 20);
    end
    push_exp(1, 0, 1);
    wait_drain("tick_to_0100pm", 700);
    check("0100pm_after_60_ticks", last_chg - prev_chg, 60);

    // Minutes 59 -> 00 by button leaves the hour alone and restarts seconds.
    for (int m = 1; m <= 59; m++) begin
      push_exp(1, m, 1);
      press(1'b0, 1'b1, 8);
      wait_drain("mins_to_0159pm", 20);
    end
    push_exp(1, 0, 1);
    press(1'b0, 1'b1, 8);
    wait_drain("mins_wrap_no_carry", 20);
    push_exp(1, 1, 1);
    wait_drain("carry_after_wrap", 700);
    check("wrap_restarts_seconds", last_chg - prev_chg, 60);

    // Bouncing contact: only the settled level counts, once.
    push_exp(1, 2, 1);
    for (int i = 0; i < 10; i++) begin
      btn_mins = (i % 2 == 0);
      cyc(2);
    end
    btn_mins = 1'b1;
    cyc(6);
    btn_mins = 1'b0;
    cyc(10);
    wait_drain("bounce_one_increment", 20);
    cyc(20);

    // Long hold: one increment, no auto-repeat.
    push_exp(1, 3, 1);
    press(1'b0, 1'b1, 100);
    wait_drain("hold_one_increment", 20);
    cyc(20);

    // Hours 01 -> 11 PM, minutes to 59, then both buttons together.
    for (int h = 2; h <= 11; h++) begin
      push_exp(h, 3, 1);
      press(1'b1, 1'b0, 8);
      wait_drain("hrs_press_pm", 20);
    end
    for (int m = 4; m <= 59; m++) begin
      push_exp(11, m, 1);
      press(1'b0, 1'b1, 8);
      wait_drain("mins_to_1159pm", 20);
    end
    push_exp(12, 0, 0);
    press(1'b1, 1'b1, 8);
    wait_drain("both_buttons_1159pm", 20);
    cyc(20);

    // Async reset in the middle of a debounce and a second.
    push_exp(12, 1, 0);
    press(1'b0, 1'b1, 8);
    wait_drain("mins_before_reset", 20);
    btn_mins = 1'b1;
    cyc(3);
    @(posedge clk_100MHz);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_display", disp(), mk(12, 0, 0));
    check("async_reset_sec_tick", sec_tick, 0);
    btn_mins = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(30);
    check("no_increment_after_reset", disp(), mk(12, 0, 0));

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
